// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
package hazard_pkg;

  // Forwarding select encoding: 0 = register file, k = result of stage k-1.
  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  // Register tags are stored at a fixed width so the struct can live here.
  // The top zero-extends narrower addresses into this field.
  localparam int TAG_RD_W = 8;

  // One in-flight destination write, as seen from ID.
  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                regwr;
    logic                memrd;
  } tag_t;

  // Width of a forwarding select able to encode 0..n.
  function automatic int fs_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority matcher for one source operand against the tag pipeline.
// The youngest matching entry (lowest index) decides both sel and ready,
// so an older ready producer can never hide a younger unready load.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int FS_W     = 2
) (
  input  logic [TAG_RD_W-1:0] src,
  input  logic                used,
  input  tag_t [NUM_FWD-1:0]  tags,
  output logic                hit,
  output logic [FS_W-1:0]     sel,
  output logic                ready
);

  logic src_zero;
  assign src_zero = (ZERO_REG != 0) && (src == '0);

  // Scan oldest to youngest so the youngest match overwrites the result.
  always_comb begin
    hit   = 1'b0;
    sel   = '0;
    ready = 1'b1;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (tags[k].valid && tags[k].regwr && (tags[k].rd == src) && used && !src_zero) begin
        hit   = 1'b1;
        sel   = FS_W'(k + 1);
        ready = !tags[k].memrd || (k >= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use stall and redirect kill, driven from a
// registered tag pipeline that mirrors destination writes in EX..WB.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_FWD    = 3,
  parameter int LOAD_LAT   = 1,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16,
  localparam int FS_W      = fs_width(NUM_FWD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwr,
  input  logic                  id_memrd,
  input  logic                  ex_redirect,
  input  logic                  hold,
  output logic [FS_W-1:0]       fwd_a,
  output logic [FS_W-1:0]       fwd_b,
  output logic                  stall,
  output logic                  kill,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      kill_cnt
);

  tag_t [NUM_FWD-1:0] pipe;
  tag_t               id_tag;

  logic            hit_a, hit_b, rdy_a, rdy_b;
  logic [FS_W-1:0] sel_a, sel_b;

  hazard_src_match #(
    .NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .FS_W(FS_W)
  ) u_match_a (
    .src(TAG_RD_W'(id_rs1)), .used(id_rs1_used), .tags(pipe),
    .hit(hit_a), .sel(sel_a), .ready(rdy_a)
  );

  hazard_src_match #(
    .NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .FS_W(FS_W)
  ) u_match_b (
    .src(TAG_RD_W'(id_rs2)), .used(id_rs2_used), .tags(pipe),
    .hit(hit_b), .sel(sel_b), .ready(rdy_b)
  );

  // Hazard decisions; kill overrides stall, and selects are zeroed while stalled.
  always_comb begin
    kill        = ex_redirect;
    stall       = id_valid && !ex_redirect && ((hit_a && !rdy_a) || (hit_b && !rdy_b));
    fwd_a       = stall ? '0 : sel_a;
    fwd_b       = stall ? '0 : sel_b;
    pc_write    = !stall && !hold;
    ifid_write  = !stall && !hold;
    idex_bubble = (stall || kill) && !hold;
  end

  // Tag for the ID instruction; a stalled or killed instruction enters as a bubble.
  always_comb begin
    id_tag.valid = id_valid && !stall && !kill;
    id_tag.rd    = TAG_RD_W'(id_rd);
    id_tag.regwr = id_regwr;
    id_tag.memrd = id_memrd;
  end

  // Advance the tag pipeline and saturating counters unless frozen by hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe      <= '0;
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else if (!hold) begin
      for (int k = NUM_FWD - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= id_tag;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (kill && (kill_cnt != {CNT_W{1'b1}}))   kill_cnt  <= kill_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the processor's combinational forwarding/stall logic.
- Owns a registered tag pipeline mirroring the in-flight destination writes of stages EX..WB.
- From that pipeline it produces operand forwarding selects, load-use stalls (configurable load latency), branch/jump kill, and saturating stall/kill performance counters.
- Sits beside the ID stage; drives the PC/IF-ID write enables and the ID/EX bubble.

Parameters:
REG_ADDR_W, 3, register address width (8 registers)
NUM_FWD, 3, tracked producer stages after ID (index 0=EX, 1=MEM, 2=WB)
LOAD_LAT, 1, stage index at which load data becomes forwardable (1 = MEM output); must be < NUM_FWD
ZERO_REG, 1, when 1, register 0 never matches (never forwarded, never stalls)
CNT_W, 16, performance counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_W  source 1 address
id_rs2  in  REG_ADDR_W  source 2 address
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_ADDR_W  destination address
id_regwr  in  1  instruction writes rd
id_memrd  in  1  instruction is a load (LW/LBu/LBs)
ex_redirect  in  1  taken branch/JMP/CALL/RET resolved this cycle
hold  in  1  global freeze (memory busy)
fwd_a  out  FS_W=$clog2(NUM_FWD+1)  rs1 source: 0=regfile, k=stage k-1 result
fwd_b  out  FS_W  rs2 source, same encoding
stall  out  1  load-use stall
kill  out  1  flush IF/ID
pc_write  out  1  PC enable
ifid_write  out  1  IF/ID enable
idex_bubble  out  1  insert NOP into ID/EX
stall_cnt  out  CNT_W  cycles with stall=1
kill_cnt  out  CNT_W  cycles with kill=1

Behaviour:
- Decision: one clock, `clk`; reset `reset` is synchronous and active-high.
- Tag pipeline: NUM_FWD entries {valid, rd, regwr, memrd}. Reset clears all entries and both counters.
- After reset, all outputs are 0 except pc_write=1 and ifid_write=1.
- Match rule for source s of entry k: valid & regwr & rd==s & used(s), and not (ZERO_REG & s==0).
- Forwarding: fwd = 1+k of the youngest matching entry (lowest k); 0 if no entry matches. Combinational, same cycle.
- Readiness: entry k is ready if !memrd, or k >= LOAD_LAT.
- Load-use: stall = id_valid & !ex_redirect & (youngest match for rs1 or rs2 is not ready). An older ready match never masks a younger unready one.
- While stall=1: fwd_a/fwd_b are don't-care, but are driven 0.
- kill = ex_redirect. kill has priority over stall; the ID instruction is discarded.
- Pipeline advance on each clk with hold=0 and reset=0:
  - Entries shift k -> k+1; the oldest entry drops off.
  - Entry 0 loads the ID instruction if id_valid & !stall & !kill; otherwise it loads a bubble (valid=0).
- hold=1: the tag pipeline and counters freeze; outputs are still computed from the frozen state.
- Enable outputs:
  - pc_write = !stall & !hold
  - ifid_write = !stall & !hold
  - idex_bubble = (stall | kill) & !hold
- Multi-cycle stalls fall out naturally. A load at entry 0 with LOAD_LAT=2 gives 2 stall cycles; with LOAD_LAT=1, 1 cycle.
- Counters:
  - Increment on a non-hold cycle when the corresponding output is 1.
  - Saturate at all-ones; no wrap.
- Reset asserted mid-stall: the next cycle sees an empty pipeline, so stall=0 and counters=0.
- Same-cycle ex_redirect + hold: kill=1 is reported, but no state changes until hold falls. The redirect source must hold ex_redirect for the duration.

Decomposition:
- Shared package (`hazard_pkg`):
  - fwd select constants FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3
  - tag entry struct typedef
  - FS_W derivation function
- One sub-module, `hazard_src_match`: per-source priority matcher that returns {hit, sel, ready}. Instantiated twice (rs1, rs2).

Test Plan:
- ADD r1; then ADD r2,r1,r3 -> fwd_a=1, stall=0, fwd_b=0; next cycle an unrelated instruction gives fwd=0.
- Write r4, one NOP, then read r4 on rs2 -> fwd_b=2; with two NOPs -> fwd_b=3; with three NOPs -> 0.
- LW r5; then ADD r6,r5,r5 -> stall=1, pc_write=0, idex_bubble=1 for 1 cycle, then fwd_a=fwd_b=2, stall_cnt=1. With LOAD_LAT=2 -> 2 stall cycles, then fwd=3.
- Write r0 then read r0, ZERO_REG=1 -> fwd_a=0, no stall; LW r0 followed by a use gives no stall.
- LW r1, dependent instruction in ID, ex_redirect=1 same cycle -> kill=1, stall=0, idex_bubble=1; next cycle entry 0 is invalid and kill_cnt=1.
- Load-use stall with hold=1 for 3 cycles -> stall stays 1, counters unchanged, pc_write=0; assert reset during stall -> next cycle stall=0, pc_write=1, counters 0.
